wb_rr_arbiter: RTL and testbench
================================

Name: wb_rr_arbiter

Overview:
- Round-robin Wishbone B4 classic arbiter. Shares one Wishbone slave port (RAM/NoC interface) between NUM_MASTERS requesters, e.g. several RV32I core bus adapters.
- Grant is held for the whole bus cycle (m_cyc high), so read-modify-write and back-to-back accesses from one master stay atomic.
- Sits between the core Wishbone masters and the shared memory/NoC slave.

Parameters:
- NUM_MASTERS, 2, number of requesting masters (2..8).
- ADDR_W, 32, address width.
- DATA_W, 32, data width; select width is DATA_W/8.
- TIMEOUT_CYCLES, 255, watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- m_cyc_i  in  NUM_MASTERS  per-master cycle request
- m_stb_i  in  NUM_MASTERS  per-master strobe
- m_we_i  in  NUM_MASTERS  per-master write enable
- m_adr_i  in  NUM_MASTERS*ADDR_W  packed addresses; master k at [k*ADDR_W +: ADDR_W]
- m_dat_i  in  NUM_MASTERS*DATA_W  packed write data
- m_sel_i  in  NUM_MASTERS*DATA_W/8  packed byte selects
- m_ack_o  out  NUM_MASTERS  per-master acknowledge
- m_err_o  out  NUM_MASTERS  per-master error (timeout)
- m_dat_o  out  DATA_W  read data, broadcast to all masters
- s_cyc_o, s_stb_o, s_we_o  out  1  slave-side controls
- s_adr_o  out  ADDR_W  slave address
- s_dat_o  out  DATA_W  slave write data
- s_sel_o  out  DATA_W/8  slave byte select
- s_ack_i  in  1  slave acknowledge
- s_dat_i  in  DATA_W  slave read data
- gnt_o  out  NUM_MASTERS  one-hot current grant (debug/perf)

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, gnt_o=0, last-winner pointer=NUM_MASTERS-1 (master 0 has top priority first).
  - All s_* controls=0, m_ack_o=0, m_err_o=0.
- State IDLE:
  - If any m_cyc_i bit is set, pick the first requester scanning upward from (last+1) mod NUM_MASTERS.
  - Register the one-hot grant and the last pointer, then go to BUSY.
  - The winner's request is forwarded to the slave no earlier than the cycle after it first asserts cyc (1-cycle arbitration latency).
- State BUSY:
  - s_cyc_o/s_stb_o/s_we_o/s_adr_o/s_dat_o/s_sel_o are combinationally muxed from the granted master.
  - m_ack_o[g]=s_ack_i for the granted master g only. All other m_ack_o bits are 0.
  - m_dat_o=s_dat_i always.
- Release: when the granted master's m_cyc_i is low at a clock edge, go to IDLE and clear gnt_o. That IDLE cycle drives s_cyc_o=0, which guarantees one dead cycle between owners.
- Other masters' cyc/stb are ignored while BUSY. They are never acked and must wait.
- Fairness: a master that has just released is the lowest priority at the next arbitration. With all masters requesting continuously, grants rotate 0,1,...,N-1,0.
- Simultaneous release and new request: release takes effect first; the new request is arbitrated in the following IDLE cycle.
- stb low inside a held cycle: grant is kept and s_stb_o=0.
- s_ack_i while IDLE or while the granted stb is low is ignored and not routed.
- Reset mid-cycle: all outputs drop immediately and the transaction is abandoned. Masters must restart.
- Without the optional feature, m_err_o is tied to 0.

Optional Feature:
- Macro: WB_ARB_TIMEOUT_EN.
- With the macro defined:
  - A counter (width $clog2(TIMEOUT_CYCLES+1)) clears on grant and on every s_ack_i.
  - It increments on each BUSY cycle with s_stb_o=1 and s_ack_i=0.
  - When it reaches TIMEOUT_CYCLES, assert m_err_o[g] for exactly one cycle with no ack.
  - Then force s_cyc_o/s_stb_o low and return to IDLE, even if the master still holds cyc.
  - That master is re-arbitrated normally with the lowest priority.
- Without the macro: no counter logic, and m_err_o=0 constantly.

Test Plan:
- Reset: rst_n=0 mid-transfer -> same cycle s_cyc_o=0, gnt_o=0, m_ack_o=0. After release, m0 and m1 request together -> gnt_o=2'b01.
- Single master: m1 write, adr=0x100, dat=0xDEADBEEF, sel=4'hF; slave acks after 2 cycles -> s_adr_o=0x100, m_ack_o=2'b10 for one cycle, gnt_o returns to 0 one cycle after m1 drops cyc.
- Contention: m0 and m1 hold cyc continuously, each doing one read then releasing for 1 cycle -> grant sequence 01,10,01,10, with one dead cycle (s_cyc_o=0) between owners.
- Atomic hold: m0 keeps cyc for 3 reads (0x0, 0x4, 0x8) while m1 requests -> m1 sees no ack until m0 drops cyc; s_adr_o never shows m1's address during m0's cycle.
- Read data: slave returns 0x12345678 for m1 -> m_dat_o=0x12345678 with m_ack_o=2'b10; m_ack_o[0]=0.
- WB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4: slave never acks m0 -> m_err_o=2'b01 pulses 4 cycles after stb, s_cyc_o drops the next cycle, and a pending m1 is granted next.

Source files
------------

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone B4 classic arbiter: NUM_MASTERS masters share one slave port; the grant is held for the whole cyc.
// Latency: the winner reaches the slave one cycle after it first raises cyc; there is one dead cycle between owners.
// Backpressure: masters that lose arbitration are not acked and wait. s_ack_i stalls only the granted master.
//
// Ports:
//   clk, rst_n                          clock, asynchronous active-low reset
//   m_cyc_i/m_stb_i/m_we_i              per-master controls, one bit per master
//   m_adr_i/m_dat_i/m_sel_i             packed per-master buses, master k at [k*W +: W]
//   m_ack_o/m_err_o                     per-master acknowledge / timeout error
//   m_dat_o                             slave read data, broadcast to all masters
//   s_cyc_o/s_stb_o/s_we_o/s_adr_o/s_dat_o/s_sel_o, s_ack_i/s_dat_i   shared slave port
//   gnt_o                               one-hot current grant
// Optional feature: define WB_ARB_TIMEOUT_EN to enable the stalled-slave watchdog (TIMEOUT_CYCLES).
module wb_rr_arbiter #(
    parameter int NUM_MASTERS    = 2,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_MASTERS-1:0]            m_cyc_i,
    input  logic [NUM_MASTERS-1:0]            m_stb_i,
    input  logic [NUM_MASTERS-1:0]            m_we_i,
    input  logic [NUM_MASTERS*ADDR_W-1:0]     m_adr_i,
    input  logic [NUM_MASTERS*DATA_W-1:0]     m_dat_i,
    input  logic [NUM_MASTERS*DATA_W/8-1:0]   m_sel_i,
    output logic [NUM_MASTERS-1:0]            m_ack_o,
    output logic [NUM_MASTERS-1:0]            m_err_o,
    output logic [DATA_W-1:0]                 m_dat_o,
    output logic                              s_cyc_o,
    output logic                              s_stb_o,
    output logic                              s_we_o,
    output logic [ADDR_W-1:0]                 s_adr_o,
    output logic [DATA_W-1:0]                 s_dat_o,
    output logic [DATA_W/8-1:0]               s_sel_o,
    input  logic                              s_ack_i,
    input  logic [DATA_W-1:0]                 s_dat_i,
    output logic [NUM_MASTERS-1:0]            gnt_o
);

    localparam int SEL_W = DATA_W / 8;
    localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t             state;
    // While BUSY, 'last' is also the index of the current owner, so it drives the mux.
    logic [IDX_W-1:0]   last;
    logic [IDX_W-1:0]   win_idx;
    logic               win_vld;
    logic               tmo_hit;

    // Scan upward from last+1 (wrapping) so the previous winner is checked last.
    always_comb begin : arb_scan
        int               cand_int;
        logic [IDX_W-1:0] cand;
        cand_int = 0;
        cand     = '0;
        win_vld  = 1'b0;
        win_idx  = last;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            cand_int = int'(last) + k;
            if (cand_int >= NUM_MASTERS) begin
                cand_int = cand_int - NUM_MASTERS;
            end
            cand = IDX_W'(cand_int);
            if (!win_vld && m_cyc_i[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam int                CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]  TMO_LIM = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] tmo_cnt;

    // Counting runs only in BUSY; sitting in IDLE keeps it cleared so every grant starts at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if (state == IDLE) begin
            tmo_cnt <= '0;
        end else if (s_ack_i) begin
            tmo_cnt <= '0;
        end else if (s_stb_o && !tmo_hit) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    assign tmo_hit = (state == BUSY) && (tmo_cnt == TMO_LIM);
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            gnt_o <= '0;
            last  <= IDX_W'(NUM_MASTERS - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        gnt_o <= NUM_MASTERS'(1) << win_idx;
                        last  <= win_idx;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    // A timeout forces release even while the owner still holds cyc.
                    if (tmo_hit || !m_cyc_i[last]) begin
                        gnt_o <= '0;
                        state <= IDLE;
                    end
                end
                default: begin
                    gnt_o <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Slave-side mux and ack/err routing. In IDLE the slave port is fully quiet,
    // which gives the dead cycle between owners and ignores stray acks.
    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        m_ack_o = '0;
        m_err_o = '0;
        m_dat_o = s_dat_i;
        if (state == BUSY) begin
            s_cyc_o       = m_cyc_i[last];
            s_stb_o       = m_stb_i[last];
            s_we_o        = m_we_i[last];
            s_adr_o       = m_adr_i[int'(last)*ADDR_W +: ADDR_W];
            s_dat_o       = m_dat_i[int'(last)*DATA_W +: DATA_W];
            s_sel_o       = m_sel_i[int'(last)*SEL_W +: SEL_W];
            // The timeout cycle reports an error instead of an ack.
            m_ack_o[last] = s_ack_i && m_stb_i[last] && !tmo_hit;
            m_err_o[last] = tmo_hit;
        end
    end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
module tb_wb_rr_arbiter;

    localparam int N   = 3;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int SW  = DW / 8;
    localparam int TMO = 4;
`ifdef WB_ARB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    m_cyc_i, m_stb_i, m_we_i;
    logic [N*AW-1:0] m_adr_i;
    logic [N*DW-1:0] m_dat_i;
    logic [N*SW-1:0] m_sel_i;
    logic [N-1:0]    m_ack_o, m_err_o, gnt_o;
    logic [DW-1:0]   m_dat_o, s_dat_o, s_dat_i;
    logic            s_cyc_o, s_stb_o, s_we_o, s_ack_i;
    logic [AW-1:0]   s_adr_o;
    logic [SW-1:0]   s_sel_o;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    wb_rr_arbiter #(
        .NUM_MASTERS   (N),
        .ADDR_W        (AW),
        .DATA_W        (DW),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .m_cyc_i (m_cyc_i),
        .m_stb_i (m_stb_i),
        .m_we_i  (m_we_i),
        .m_adr_i (m_adr_i),
        .m_dat_i (m_dat_i),
        .m_sel_i (m_sel_i),
        .m_ack_o (m_ack_o),
        .m_err_o (m_err_o),
        .m_dat_o (m_dat_o),
        .s_cyc_o (s_cyc_o),
        .s_stb_o (s_stb_o),
        .s_we_o  (s_we_o),
        .s_adr_o (s_adr_o),
        .s_dat_o (s_dat_o),
        .s_sel_o (s_sel_o),
        .s_ack_i (s_ack_i),
        .s_dat_i (s_dat_i),
        .gnt_o   (gnt_o)
    );

    // Reference model: owner is the granted master index or -1 when the bus is free;
    // last is the most recent winner; cnt counts unacked strobe cycles of the owner.
    int mdl_owner, mdl_last, mdl_cnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdl_owner <= -1;
            mdl_last  <= N - 1;
            mdl_cnt   <= 0;
        end else if (mdl_owner < 0) begin : arb
            int pick;
            pick = -1;
            for (int k = 1; k <= N; k++) begin
                if (pick < 0 && m_cyc_i[(mdl_last + k) % N]) pick = (mdl_last + k) % N;
            end
            if (pick >= 0) begin
                mdl_owner <= pick;
                mdl_last  <= pick;
                mdl_cnt   <= 0;
            end
        end else if (TMO_EN && mdl_cnt == TMO) begin
            mdl_owner <= -1;
        end else if (!m_cyc_i[mdl_owner]) begin
            mdl_owner <= -1;
        end else if (s_ack_i) begin
            mdl_cnt <= 0;
        end else if (m_stb_i[mdl_owner]) begin
            mdl_cnt <= mdl_cnt + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m_cyc_i = '0; m_stb_i = '0; m_we_i = '0;
        m_adr_i = '0; m_dat_i = '0; m_sel_i = '0;
        s_ack_i = 1'b0; s_dat_i = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        vectors++;
        if ({gnt_o, s_cyc_o, s_stb_o, m_ack_o, m_err_o} !== '0) begin
            miscompares++;
            $display("FAIL reset_state: got gnt=%b cyc=%b stb=%b ack=%b err=%b, want all 0",
                     gnt_o, s_cyc_o, s_stb_o, m_ack_o, m_err_o);
        end
        tick();
        rst_n = 1'b1;
        m_cyc_i[0] = 1'b1; m_stb_i[0] = 1'b1;
        tick();
        s_ack_i = 1'b1;
        #1;
        vectors++;
        if ({s_cyc_o, gnt_o} !== {1'b1, 3'b001}) begin
            miscompares++;
            $display("FAIL reset_pre_busy: got cyc=%b gnt=%b, want 1 001", s_cyc_o, gnt_o);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({s_cyc_o, gnt_o, m_ack_o} !== '0) begin
            miscompares++;
            $display("FAIL reset_midcycle: got cyc=%b gnt=%b ack=%b, want 0", s_cyc_o, gnt_o, m_ack_o);
        end
        clear_inputs();
        tick();
        rst_n = 1'b1;
        tick();
        m_cyc_i = 3'b011; m_stb_i = 3'b011;
        tick();
        vectors++;
        if (gnt_o !== 3'b001) begin
            miscompares++;
            $display("FAIL reset_first_prio: got gnt=%b, want 001", gnt_o);
        end
    endtask

    task automatic test_single();
        do_reset();
        m_cyc_i[1] = 1'b1; m_stb_i[1] = 1'b1; m_we_i[1] = 1'b1;
        m_adr_i[AW +: AW] = 32'h100; m_dat_i[DW +: DW] = 32'hDEADBEEF; m_sel_i[SW +: SW] = 4'hF;
        #1;
        vectors++;
        if ({gnt_o, s_cyc_o} !== 4'b0000) begin
            miscompares++;
            $display("FAIL single_latency: got gnt=%b cyc=%b, want 000 0", gnt_o, s_cyc_o);
        end
        tick();
        vectors++;
        if ({gnt_o, s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o, m_ack_o} !==
            {3'b010, 3'b111, 32'h100, 32'hDEADBEEF, 4'hF, 3'b000}) begin
            miscompares++;
            $display("FAIL single_fwd: got gnt=%b cyc/stb/we=%b%b%b adr=%h dat=%h sel=%h ack=%b",
                     gnt_o, s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o, m_ack_o);
        end
        tick();
        tick();
        s_ack_i = 1'b1;
        #1;
        vectors++;
        if (m_ack_o !== 3'b010) begin
            miscompares++;
            $display("FAIL single_ack: got ack=%b, want 010", m_ack_o);
        end
        tick();
        s_ack_i = 1'b0; m_cyc_i[1] = 1'b0; m_stb_i[1] = 1'b0;
        #1;
        vectors++;
        if ({m_ack_o, gnt_o} !== {3'b000, 3'b010}) begin
            miscompares++;
            $display("FAIL single_drop: got ack=%b gnt=%b, want 000 010", m_ack_o, gnt_o);
        end
        tick();
        vectors++;
        if ({gnt_o, s_cyc_o} !== 4'b0000) begin
            miscompares++;
            $display("FAIL single_release: got gnt=%b cyc=%b, want 000 0", gnt_o, s_cyc_o);
        end
    endtask

    task automatic test_contention();
        int exp_idx;
        do_reset();
        m_cyc_i = 3'b011; m_stb_i = 3'b011;
        exp_idx = 0;
        for (int g = 0; g < 4; g++) begin
            tick();
            s_ack_i = 1'b1;
            #1;
            vectors++;
            if ({gnt_o, m_ack_o} !== {3'(1 << exp_idx), 3'(1 << exp_idx)}) begin
                miscompares++;
                $display("FAIL contention_grant%0d: got gnt=%b ack=%b, want master %0d", g, gnt_o, m_ack_o, exp_idx);
            end
            tick();
            s_ack_i = 1'b0; m_cyc_i[exp_idx] = 1'b0; m_stb_i[exp_idx] = 1'b0;
            tick();
            m_cyc_i[exp_idx] = 1'b1; m_stb_i[exp_idx] = 1'b1;
            #1;
            vectors++;
            if ({gnt_o, s_cyc_o} !== 4'b0000) begin
                miscompares++;
                $display("FAIL contention_dead%0d: got gnt=%b cyc=%b, want 000 0", g, gnt_o, s_cyc_o);
            end
            exp_idx = 1 - exp_idx;
        end
    endtask

    task automatic test_atomic();
        do_reset();
        m_cyc_i = 3'b011; m_stb_i = 3'b011;
        m_adr_i[AW +: AW] = 32'h200;
        for (int i = 0; i < 3; i++) begin
            tick();
            m_adr_i[0 +: AW] = 32'(i * 4);
            s_ack_i = 1'b1;
            #1;
            vectors++;
            if ({s_adr_o, m_ack_o} !== {32'(i * 4), 3'b001}) begin
                miscompares++;
                $display("FAIL atomic_read%0d: got adr=%h ack=%b, want %h 001", i, s_adr_o, m_ack_o, i * 4);
            end
        end
        tick();
        m_cyc_i[0] = 1'b0; m_stb_i[0] = 1'b0;
        #1;
        vectors++;
        if ({m_ack_o, s_cyc_o} !== 4'b0000) begin
            miscompares++;
            $display("FAIL atomic_release: got ack=%b cyc=%b, want 000 0", m_ack_o, s_cyc_o);
        end
        tick();
        vectors++;
        if ({m_ack_o, s_cyc_o, gnt_o} !== 7'b0) begin
            miscompares++;
            $display("FAIL atomic_idle_ack: got ack=%b cyc=%b gnt=%b, want all 0", m_ack_o, s_cyc_o, gnt_o);
        end
        s_ack_i = 1'b0;
        tick();
        vectors++;
        if ({gnt_o, s_adr_o} !== {3'b010, 32'h200}) begin
            miscompares++;
            $display("FAIL atomic_next_owner: got gnt=%b adr=%h, want 010 200", gnt_o, s_adr_o);
        end
    endtask

    task automatic test_read_data();
        do_reset();
        m_cyc_i[1] = 1'b1; m_stb_i[1] = 1'b1; m_adr_i[AW +: AW] = 32'h40;
        tick();
        m_stb_i[1] = 1'b0; s_ack_i = 1'b1; s_dat_i = 32'hAAAA5555;
        #1;
        vectors++;
        if ({gnt_o, s_cyc_o, s_stb_o, m_ack_o} !== {3'b010, 2'b10, 3'b000}) begin
            miscompares++;
            $display("FAIL stb_low_hold: got gnt=%b cyc=%b stb=%b ack=%b, want 010 1 0 000",
                     gnt_o, s_cyc_o, s_stb_o, m_ack_o);
        end
        tick();
        m_stb_i[1] = 1'b1; s_dat_i = 32'h12345678;
        #1;
        vectors++;
        if ({m_dat_o, m_ack_o} !== {32'h12345678, 3'b010}) begin
            miscompares++;
            $display("FAIL read_data: got dat=%h ack=%b, want 12345678 010", m_dat_o, m_ack_o);
        end
    endtask

`ifdef WB_ARB_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        m_cyc_i = 3'b011; m_stb_i = 3'b011;
        for (int c = 1; c <= TMO; c++) begin
            tick();
            vectors++;
            if ({m_err_o, s_cyc_o, gnt_o} !== {3'b000, 1'b1, 3'b001}) begin
                miscompares++;
                $display("FAIL timeout_wait%0d: got err=%b cyc=%b gnt=%b, want 000 1 001", c, m_err_o, s_cyc_o, gnt_o);
            end
        end
        tick();
        vectors++;
        if ({m_err_o, m_ack_o} !== {3'b001, 3'b000}) begin
            miscompares++;
            $display("FAIL timeout_err: got err=%b ack=%b, want 001 000", m_err_o, m_ack_o);
        end
        tick();
        vectors++;
        if ({s_cyc_o, m_err_o, gnt_o} !== 7'b0) begin
            miscompares++;
            $display("FAIL timeout_drop: got cyc=%b err=%b gnt=%b, want all 0", s_cyc_o, m_err_o, gnt_o);
        end
        tick();
        vectors++;
        if (gnt_o !== 3'b010) begin
            miscompares++;
            $display("FAIL timeout_regrant: got gnt=%b, want 010", gnt_o);
        end
    endtask
`endif

    task automatic test_random();
        logic [111:0] obs, expv;
        logic [N-1:0] e_gnt, e_ack, e_err;
        logic         e_cyc, e_stb, e_we, tmo;
        logic [AW-1:0] e_adr;
        logic [DW-1:0] e_dat;
        logic [SW-1:0] e_sel;
        int o;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            tick();
            for (int k = 0; k < N; k++) begin
                if (m_cyc_i[k]) begin
                    if ($urandom_range(0, 5) == 0) m_cyc_i[k] = 1'b0;
                end else if ($urandom_range(0, 2) == 0) begin
                    m_cyc_i[k] = 1'b1;
                end
                m_stb_i[k] = m_cyc_i[k] && ($urandom_range(0, 3) != 0);
                m_we_i[k]  = 1'($urandom_range(0, 1));
                m_adr_i[k*AW +: AW] = $urandom;
                m_dat_i[k*DW +: DW] = $urandom;
                m_sel_i[k*SW +: SW] = 4'($urandom_range(0, 15));
            end
            s_ack_i = 1'($urandom_range(0, 1));
            s_dat_i = $urandom;
            #1;
            o = mdl_owner;
            e_gnt = '0; e_ack = '0; e_err = '0;
            e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0; e_adr = '0; e_dat = '0; e_sel = '0;
            tmo = 1'b0;
            if (o >= 0) begin
                tmo      = TMO_EN && (mdl_cnt == TMO);
                e_gnt[o] = 1'b1;
                e_cyc    = m_cyc_i[o];
                e_stb    = m_stb_i[o];
                e_we     = m_we_i[o];
                e_adr    = m_adr_i[o*AW +: AW];
                e_dat    = m_dat_i[o*DW +: DW];
                e_sel    = m_sel_i[o*SW +: SW];
                e_ack[o] = s_ack_i && m_stb_i[o] && !tmo;
                e_err[o] = tmo;
            end
            expv = {e_gnt, e_cyc, e_stb, e_we, e_adr, e_dat, e_sel, e_ack, e_err, s_dat_i};
            obs  = {gnt_o, s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o, m_ack_o, m_err_o, m_dat_o};
            vectors++;
            if (obs !== expv) begin
                miscompares++;
                $display("FAIL random_cycle%0d: got %h want %h", i, obs, expv);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_atomic();
        test_read_data();
`ifdef WB_ARB_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
